vga_scan_arbiter: RTL and testbench

Generates the 1024x768@60 Hz raster timing (65 MHz pixel clock) and owns the single-port sample RAM that feeds the display. It multiplexes the RAM between the display fetch path and the capture writer. The display has absolute priority during the visible area, and capture writes are granted only in blanking. It sits between the capture engine and the VGA output pins and replaces the free-running horizontal counter with one line/frame sequencer.

---
 rtl/vga_scan_arbiter_if.sv | 25 ++
 rtl/vga_scan_arbiter.sv | 104 ++++++++++
 tb/tb_vga_scan_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_arbiter_if.sv
// Capture-writer and sample-RAM bus of vga_scan_arbiter.
// master: the arbiter side; slave: the capture engine plus RAM side.
interface vga_scan_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              cap_req;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cap_req, cap_addr, cap_data, mem_rdata,
        output cap_gnt, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output cap_req, cap_addr, cap_data, mem_rdata,
        input  cap_gnt, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_scan_arbiter.sv
// 1024x768@60 raster sequencer that shares the sample RAM between display fetch and capture writes.
// Optional macro FRAME_LOCK_EN restricts capture grants to vertical blanking.
module vga_scan_arbiter #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_TOTAL   = 1344,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_TOTAL   = 806,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [10:0]       pixel_x,
    output logic [9:0]        line_y,
    output logic              hsync,
    output logic              vsync,
    output logic              display_en,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_start,
    vga_scan_arbiter_if.master bus
);

    logic [10:0] h;
    logic [9:0]  v;
    logic        fetch_slot;
    logic        grant_window;
    logic        gnt;
    logic        hs0, vs0, fs0;
    logic        de1, hs1, vs1, fs1;

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == 11'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 10'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    assign fetch_slot = (h < 11'(H_VISIBLE)) && (v < 10'(V_VISIBLE));

`ifdef FRAME_LOCK_EN
    assign grant_window = (v >= 10'(V_VISIBLE));
`else
    assign grant_window = ~fetch_slot;
`endif

    assign gnt         = bus.cap_req & grant_window & ~rst;
    assign bus.cap_gnt = gnt;

    // Display fetch outranks capture; an ungranted request simply waits.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (fetch_slot) begin
            bus.mem_addr = h[ADDR_W-1:0];
        end else if (gnt) begin
            bus.mem_addr  = bus.cap_addr;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.cap_data;
        end
    end

    assign hs0 = ~((h >= 11'(H_VISIBLE + H_FRONT)) && (h < 11'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vs0 = ~((v >= 10'(V_VISIBLE + V_FRONT)) && (v < 10'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign fs0 = (h == 11'd0) && (v == 10'd0);

    // Stage 1 lines the timing flags up with the RAM read; stage 2 drives the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            de1         <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            fs1         <= 1'b0;
            display_en  <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            pix_data    <= '0;
        end else begin
            de1         <= fetch_slot;
            hs1         <= hs0;
            vs1         <= vs0;
            fs1         <= fs0;
            display_en  <= de1;
            hsync       <= hs1;
            vsync       <= vs1;
            frame_start <= fs1;
            pix_data    <= de1 ? bus.mem_rdata : '0;
        end
    end

    assign pixel_x = h;
    assign line_y  = v;

endmodule

// File: tb/tb_vga_scan_arbiter.sv
// Directed bench for vga_scan_arbiter: full horizontal timing, shortened frame height to keep runs short.
module tb_vga_scan_arbiter;
    localparam int HT    = 1344;
    localparam int HV    = 1024;
    localparam int VV    = 4;
    localparam int VF    = 3;
    localparam int VS    = 6;
    localparam int VT    = 14;
    localparam int FRAME = HT * VT;
`ifdef FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic [10:0] pixel_x;
    logic [9:0]  line_y;
    logic        hsync, vsync, display_en, frame_start;
    logic [3:0]  pix_data;
    logic [3:0]  ram [1024];
    int          errors = 0;
    int          checks = 0;
    int          tx = 0;
    int          ty = 0;

    vga_scan_arbiter_if #(.ADDR_W(10), .DATA_W(4)) bus ();

    vga_scan_arbiter #(
        .H_VISIBLE(HV), .H_FRONT(24), .H_SYNC(136), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .ADDR_W(10), .DATA_W(4)
    ) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .line_y(line_y),
        .hsync(hsync), .vsync(vsync), .display_en(display_en),
        .pix_data(pix_data), .frame_start(frame_start), .bus(bus)
    );

    always #5 clk = ~clk;

    // Sample RAM with one-cycle read latency, preloaded with RAM[i] = i[3:0].
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 4'(i);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            tx = 0;
            ty = 0;
        end else if (tx == HT - 1) begin
            tx = 0;
            ty = (ty == VT - 1) ? 0 : ty + 1;
        end else begin
            tx++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(tx == h && ty == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cap_req = 1'b1;
        bus.cap_addr = 10'h11;
        bus.cap_data = 4'hF;
        repeat (3) tick();
        preload = 1'b0;
        #1;
        checks++; if (pixel_x !== 11'd0) begin errors++; $display("[TB] FAIL reset_pixel_x: got %0d expected 0", pixel_x); end
        checks++; if (line_y !== 10'd0) begin errors++; $display("[TB] FAIL reset_line_y: got %0d expected 0", line_y); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync: got %b expected 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync: got %b expected 1", vsync); end
        checks++; if (display_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_display_en: got %b expected 0", display_en); end
        checks++; if (pix_data !== 4'd0) begin errors++; $display("[TB] FAIL reset_pix_data: got %0d expected 0", pix_data); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (bus.cap_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_cap_gnt: got %b expected 0", bus.cap_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    endtask

    task automatic test_pixels();
        int         deBad = 0;
        int         pixBad = 0;
        int         firstDe = -1;
        int         gntAt = -1;
        logic       dropNow = 1'b0;
        logic       expDe;
        logic [3:0] expPix;
        logic [9:0] gAddr = '0;
        logic [3:0] gData = '0;
        logic       gWe = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.cap_gnt !== 1'b0) begin errors++; $display("[TB] FAIL pending_gnt_h0: got %b expected 0", bus.cap_gnt); end
        for (int i = 1; i <= HT; i++) begin
            tick();
            if (dropNow) begin
                bus.cap_req = 1'b0;
                dropNow = 1'b0;
            end
            #1;
            expDe  = (i >= 2 && i <= HV + 1);
            expPix = expDe ? 4'(i - 2) : 4'd0;
            if (display_en !== expDe) deBad++;
            if (pix_data !== expPix) pixBad++;
            if (display_en === 1'b1 && firstDe < 0) firstDe = i;
            if (bus.cap_gnt === 1'b1 && gntAt < 0) begin
                gntAt = i;
                gWe = bus.mem_we;
                gAddr = bus.mem_addr;
                gData = bus.mem_wdata;
                dropNow = 1'b1;
            end
        end
        bus.cap_req = 1'b0;
        checks++; if (firstDe != 2) begin errors++; $display("[TB] FAIL first_display_en: got cycle %0d expected 2", firstDe); end
        checks++; if (deBad != 0) begin errors++; $display("[TB] FAIL display_en_line0: got %0d bad cycles expected 0", deBad); end
        checks++; if (pixBad != 0) begin errors++; $display("[TB] FAIL pix_data_line0: got %0d bad cycles expected 0", pixBad); end
        checks++; if (gntAt != (LOCK ? -1 : HV)) begin errors++; $display("[TB] FAIL pending_first_gnt: got h=%0d expected %0d", gntAt, LOCK ? -1 : HV); end
        if (gntAt >= 0) begin
            checks++; if (gWe !== 1'b1 || gAddr !== 10'h11 || gData !== 4'hF) begin
                errors++; $display("[TB] FAIL pending_gnt_bus: got we=%b addr=%h data=%h expected we=1 addr=011 data=f", gWe, gAddr, gData);
            end
        end
        checks++; if (ram[17] !== (LOCK ? 4'h1 : 4'hF)) begin errors++; $display("[TB] FAIL pending_write: got %h expected %h", ram[17], LOCK ? 4'h1 : 4'hF); end
        checks++; if (pixel_x !== 11'd0 || line_y !== 10'd1) begin errors++; $display("[TB] FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", pixel_x, line_y); end
    endtask

    task automatic test_frame_timing();
        int   hsFalls = 0, hsPerBad = 0, hsRunBad = 0, hsRun = 0, lastHs = -1;
        int   vsFalls = 0, vsLow = 0, lastVs = -1, vsPer = -1;
        int   fsCount = 0, lastFs = -1, fsPer = -1, deCount = 0;
        logic prevHs, prevVs;
        prevHs = hsync;
        prevVs = vsync;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (prevHs === 1'b1 && hsync === 1'b0) begin
                hsFalls++;
                if (lastHs >= 0 && i - lastHs != HT) hsPerBad++;
                lastHs = i;
                hsRun = 1;
            end else if (hsync === 1'b0) begin
                hsRun++;
            end
            if (prevHs === 1'b0 && hsync === 1'b1 && lastHs >= 0 && hsRun != 136) hsRunBad++;
            if (prevVs === 1'b1 && vsync === 1'b0) begin
                vsFalls++;
                if (lastVs >= 0) vsPer = i - lastVs;
                lastVs = i;
            end
            if (vsync === 1'b0) vsLow++;
            if (frame_start === 1'b1) begin
                fsCount++;
                if (lastFs >= 0) fsPer = i - lastFs;
                lastFs = i;
            end
            if (display_en === 1'b1) deCount++;
            prevHs = hsync;
            prevVs = vsync;
        end
        checks++; if (hsFalls != 2 * VT) begin errors++; $display("[TB] FAIL hsync_pulses: got %0d expected %0d", hsFalls, 2 * VT); end
        checks++; if (hsPerBad != 0) begin errors++; $display("[TB] FAIL hsync_period: got %0d bad periods expected 0", hsPerBad); end
        checks++; if (hsRunBad != 0) begin errors++; $display("[TB] FAIL hsync_width: got %0d bad widths expected 0", hsRunBad); end
        checks++; if (vsFalls != 2) begin errors++; $display("[TB] FAIL vsync_pulses: got %0d expected 2", vsFalls); end
        checks++; if (vsLow != 2 * VS * HT) begin errors++; $display("[TB] FAIL vsync_width: got %0d expected %0d", vsLow, 2 * VS * HT); end
        checks++; if (vsPer != FRAME) begin errors++; $display("[TB] FAIL vsync_period: got %0d expected %0d", vsPer, FRAME); end
        checks++; if (fsCount != 2) begin errors++; $display("[TB] FAIL frame_start_count: got %0d expected 2", fsCount); end
        checks++; if (fsPer != FRAME) begin errors++; $display("[TB] FAIL frame_start_period: got %0d expected %0d", fsPer, FRAME); end
        checks++; if (deCount != 2 * VV * HV) begin errors++; $display("[TB] FAIL display_en_count: got %0d expected %0d", deCount, 2 * VV * HV); end
    endtask

    task automatic test_capture_wait();
        int n = 0;
        int expH = LOCK ? 0 : HV;
        int expV = LOCK ? VV : 1;
        run_to(500, 1);
        checks++; if (pixel_x !== 11'd500 || line_y !== 10'd1) begin errors++; $display("[TB] FAIL cap_start_pos: got x=%0d y=%0d expected x=500 y=1", pixel_x, line_y); end
        bus.cap_req = 1'b1;
        bus.cap_addr = 10'h3A;
        bus.cap_data = 4'h5;
        #1;
        while (bus.cap_gnt !== 1'b1 && n < FRAME) begin
            tick();
            #1;
            n++;
        end
        checks++; if (n >= FRAME || tx != expH || ty != expV) begin
            errors++; $display("[TB] FAIL cap_first_gnt: got h=%0d v=%0d after %0d cycles expected h=%0d v=%0d", tx, ty, n, expH, expV);
        end
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h3A || bus.mem_wdata !== 4'h5) begin
            errors++; $display("[TB] FAIL cap_gnt_bus: got we=%b addr=%h data=%h expected we=1 addr=03a data=5", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.cap_req = 1'b0;
        #1;
        checks++; if (ram[58] !== 4'h5) begin errors++; $display("[TB] FAIL cap_write: got %h expected 5", ram[58]); end
        checks++; if (bus.cap_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL cap_release: got gnt=%b we=%b expected 0 0", bus.cap_gnt, bus.mem_we); end
    endtask

    task automatic test_back_to_back();
        int fetchGnt = 0, blankGnt = 0, weBad = 0, run = 0, maxRun = 0;
        run_to(1000, 2);
        checks++; if (pixel_x !== 11'd1000 || line_y !== 10'd2) begin errors++; $display("[TB] FAIL b2b_start_pos: got x=%0d y=%0d expected x=1000 y=2", pixel_x, line_y); end
        bus.cap_req = 1'b1;
        bus.cap_addr = 10'h20;
        bus.cap_data = 4'hC;
        #1;
        for (int i = 0; i < HT + 24; i++) begin
            if (bus.cap_gnt === 1'b1) begin
                if (tx < HV && ty < VV) fetchGnt++;
                else blankGnt++;
                run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
            if (bus.mem_we !== bus.cap_gnt) weBad++;
            tick();
            #1;
        end
        bus.cap_req = 1'b0;
        checks++; if (fetchGnt != 0) begin errors++; $display("[TB] FAIL b2b_fetch_gnt: got %0d expected 0", fetchGnt); end
        checks++; if (blankGnt != (LOCK ? 0 : 320)) begin errors++; $display("[TB] FAIL b2b_blank_gnt: got %0d expected %0d", blankGnt, LOCK ? 0 : 320); end
        checks++; if (maxRun != (LOCK ? 0 : 320)) begin errors++; $display("[TB] FAIL b2b_run: got %0d expected %0d", maxRun, LOCK ? 0 : 320); end
        checks++; if (weBad != 0) begin errors++; $display("[TB] FAIL b2b_mem_we: got %0d bad cycles expected 0", weBad); end
    endtask

    task automatic test_reset_mid();
        run_to(1100, 3);
        bus.cap_req = 1'b1;
        bus.cap_addr = 10'h3C;
        bus.cap_data = 4'h2;
        rst = 1'b1;
        #1;
        checks++; if (bus.cap_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_write: got gnt=%b we=%b expected 0 0", bus.cap_gnt, bus.mem_we); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (pixel_x !== 11'd0 || line_y !== 10'd0) begin errors++; $display("[TB] FAIL rst_mid_pos: got x=%0d y=%0d expected x=0 y=0", pixel_x, line_y); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || display_en !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_cycle1: got hs=%b vs=%b de=%b expected 1 1 0", hsync, vsync, display_en);
        end
        checks++; if (bus.cap_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_gnt: got %b expected 0", bus.cap_gnt); end
        tick();
        #1;
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || display_en !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_cycle2: got hs=%b vs=%b de=%b expected 1 1 0", hsync, vsync, display_en);
        end
        tick();
        #1;
        checks++; if (display_en !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_resume: got de=%b fs=%b expected 1 1", display_en, frame_start); end
        bus.cap_req = 1'b0;
    endtask

    task automatic test_vblank();
        run_to(100, VV);
        bus.cap_req = 1'b1;
        bus.cap_addr = 10'h3B;
        bus.cap_data = 4'h9;
        #1;
        checks++; if (bus.cap_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h3B) begin
            errors++; $display("[TB] FAIL vblank_gnt: got gnt=%b we=%b addr=%h expected 1 1 03b", bus.cap_gnt, bus.mem_we, bus.mem_addr);
        end
        checks++; if (display_en !== 1'b0 || pix_data !== 4'd0) begin errors++; $display("[TB] FAIL vblank_blank: got de=%b pix=%h expected 0 0", display_en, pix_data); end
        tick();
        bus.cap_req = 1'b0;
        #1;
        checks++; if (ram[59] !== 4'h9) begin errors++; $display("[TB] FAIL vblank_write: got %h expected 9", ram[59]); end
    endtask

    task automatic test_wrap();
        run_to(HT - 1, VT - 1);
        checks++; if (pixel_x !== 11'd1343 || line_y !== 10'(VT - 1)) begin errors++; $display("[TB] FAIL wrap_pre: got x=%0d y=%0d expected x=1343 y=%0d", pixel_x, line_y, VT - 1); end
        tick();
        #1;
        checks++; if (pixel_x !== 11'd0 || line_y !== 10'd0 || frame_start !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_edge: got x=%0d y=%0d fs=%b expected 0 0 0", pixel_x, line_y, frame_start);
        end
        tick();
        #1;
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL wrap_fs_early: got %b expected 0", frame_start); end
        tick();
        #1;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL wrap_fs: got %b expected 1", frame_start); end
        tick();
        #1;
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL wrap_fs_pulse: got %b expected 0", frame_start); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cap_req = 1'b0;
        bus.cap_addr = '0;
        bus.cap_data = '0;
        test_reset();
        test_pixels();
        test_frame_timing();
        test_capture_wait();
        test_back_to_back();
        test_reset_mid();
        test_vblank();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
